// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control for the RV64I memory stage.
// Accepts one operation at a time, runs a single-outstanding data-memory
// transaction for legal aligned accesses and returns extended load data or
// an error code through a one-cycle response pulse.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic [63:0] dmem_addr,
    output logic        dmem_we,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wmask,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [1:0]  resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;

    state_t      state_q, state_d;
    logic        init_q, init_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  ltype_q, ltype_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;

    logic        illegal, misal;
    logic [1:0]  sz;           // log2 of access size in bytes
    logic [63:0] st_wdata;
    logic [7:0]  st_mask;
    logic [63:0] ld_shift, ld_ext;

    // Decode the offered operation: legality, size, alignment and store lanes
    always_comb begin
        illegal  = (mem_read & mem_write) | (mem_read & (load_type == 3'b000)) |
                   (mem_write & ~store_type[2]) | (~mem_read & ~mem_write);
        // load_type[1:0] is 01/10/11 for byte/half/word, 00 only for ld
        if (mem_read) sz = (load_type == 3'b100) ? 2'd3 : load_type[1:0] - 2'd1;
        else          sz = store_type[1:0];
        misal    = 1'b0;
        st_wdata = wdata;
        st_mask  = 8'hFF;
        case (sz)
            2'd0: begin
                st_wdata = {8{wdata[7:0]}};
                st_mask  = 8'h01 << addr[2:0];
            end
            2'd1: begin
                misal    = addr[0];
                st_wdata = {4{wdata[15:0]}};
                st_mask  = 8'h03 << addr[2:0];
            end
            2'd2: begin
                misal    = addr[1:0] != 2'b00;
                st_wdata = {2{wdata[31:0]}};
                st_mask  = 8'h0F << addr[2:0];
            end
            default: begin
                misal    = addr[2:0] != 3'b000;
                st_wdata = wdata;
                st_mask  = 8'hFF;
            end
        endcase
    end

    // Extract and extend the load field from the aligned doubleword
    always_comb begin
        ld_shift = dmem_rdata >> {off_q, 3'b000};
        case (ltype_q)
            3'b001:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
            3'b010:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b011:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b101:  ld_ext = {56'd0, ld_shift[7:0]};
            3'b110:  ld_ext = {48'd0, ld_shift[15:0]};
            3'b111:  ld_ext = {32'd0, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Next-state and register updates for the request/response FSM
    always_comb begin
        state_d   = state_q;
        init_d    = 1'b1;
        is_load_d = is_load_q;
        ltype_d   = ltype_q;
        off_d     = off_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                is_load_d = mem_read;
                ltype_d   = load_type;
                off_d     = addr[2:0];
                addr_d    = {addr[63:3], 3'b000};
                we_d      = mem_write;
                wdata_d   = mem_write ? st_wdata : 64'd0;
                wmask_d   = mem_write ? st_mask : 8'h00;
                if (illegal) begin
                    rdata_d = 64'd0;
                    err_d   = ERR_ILL;
                    state_d = DONE;
                end else if (misal) begin
                    rdata_d = 64'd0;
                    err_d   = ERR_MIS;
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: if (dmem_ready) begin
                if (is_load_q) begin
                    state_d = WAIT;
                end else begin
                    rdata_d = 64'd0;
                    err_d   = ERR_OK;
                    state_d = DONE;
                end
            end
            WAIT: if (dmem_rvalid) begin
                rdata_d = ld_ext;
                err_d   = ERR_OK;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            is_load_q <= 1'b0;
            ltype_q   <= 3'd0;
            off_q     <= 3'd0;
            addr_q    <= 64'd0;
            we_q      <= 1'b0;
            wdata_q   <= 64'd0;
            wmask_q   <= 8'd0;
            rdata_q   <= 64'd0;
            err_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            is_load_q <= is_load_d;
            ltype_q   <= ltype_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // init_q keeps req_ready low until the first edge after reset release
    assign req_ready  = (state_q == IDLE) & init_q;
    assign dmem_valid = (state_q == REQ);
    assign dmem_addr  = addr_q;
    assign dmem_we    = we_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wmask = wmask_q;
    assign resp_valid = (state_q == DONE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
